twiddle_negate_arbiter: RTL and testbench
=========================================

# twiddle_negate_arbiter

- Shares one pipelined conditional-negate unit among NREQ requesters in the FFT pipeline.
- The unit applies trivial twiddles (0, +1, −1) to W-bit two's-complement samples.
- Requesters are served by round-robin arbitration. Results return tagged with the requester id, under a valid/ready handshake with backpressure.
- Sits between the butterfly stage controllers and the stage output muxing, replacing per-lane negate/select logic.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 10, sample and coefficient width
- IDW, $clog2(NREQ), id width (derived; not overridden)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_coef  in  NREQ*W  coefficient words, requester i at [i*W +: W]
- req_data  in  NREQ*W  sample words, requester i at [i*W +: W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  W  result sample
- out_id  out  IDW  index of the requester that produced out_data
- busy  out  1  high while any pipeline stage holds data

## Operation
- Coefficient decode (per accepted request):
  - coef == 0 → ZERO: result 0.
  - coef[W-1] == 1 → NEG: result ~data + 1, W-bit.
  - otherwise → PASS: result data.
- Arbitration:
  - Round-robin pointer ptr (IDW bits), reset to 0.
  - Candidates are scanned ptr, ptr+1, …, wrapping modulo NREQ; the first requester with req_valid high is the grant g.
  - req_ready[g] = s1_accept; all other req_ready bits are 0.
  - On a handshake (req_valid[g] & req_ready[g]), ptr ← (g+1) mod NREQ. The pointer does not change on cycles without a handshake.
- Pipeline: two register stages, each with a valid bit.
  - S1 holds op code (ZERO/NEG/PASS), data and id.
  - S2 holds the computed result and id; S2 drives out_valid, out_data and out_id.
- Advance rules:
  - s2_accept = !s2_valid | out_ready.
  - s1_accept = !s1_valid | s2_accept.
  - S1 loads on a handshake. Otherwise it clears if it advanced, and holds if it stalled.
  - S2 loads from S1 when s1_valid & s2_accept. It clears on an out handshake with S1 empty.
- The pipeline is fully elastic: one result per cycle sustained while out_ready stays high.
- busy = s1_valid | s2_valid.
- Reset:
  - Output reset values: req_ready 0, out_valid 0, out_data 0, out_id 0, busy 0. req_ready stays 0 while rst is high.
  - Internal state: ptr 0, both stages empty.
  - Reset mid-operation discards in-flight data with no partial output. The first grant after reset starts scanning at requester 0.
- Boundary conditions:
  - Stall: while out_valid & !out_ready, out_data and out_id hold stable. A third request is refused (req_ready all 0) once S1 and S2 are both full.
  - Every requester may drop req_valid without a handshake. The requester must keep data and coef stable while valid is high and ready is low.
  - No requests valid: no grant, ptr holds, bubbles propagate.

## Timing
- Latency: a handshake at edge t gives out_valid high after edge t+1, sampled by downstream at edge t+2.
- Throughput: 1 result per clk with no stall.
- req_ready is combinational from req_valid, ptr and the stage valids and out_ready. There is no combinational path from req_data or req_coef to any output.
- out_data, out_id and out_valid are registered.

## Configuration
- TWNEG_SAT_EN:
  - Defined: NEG of the most-negative value (data = 1 followed by W-1 zeros) saturates to the most-positive value, 0 followed by W-1 ones (W=10: −512 → +511).
  - Undefined: NEG wraps, so −512 → −512 (10'h200).
  - All other decode behaviour is identical in both builds.

## Test plan
- Reset then single request: req0 data=10'd37, coef=10'h200 (NEG) → out_valid two edges later, out_data=10'h3DB (−37), out_id=0; busy high for 2 cycles.
- Decode: coef=0, data=123 → 0. coef=10'h001, data=123 → 123. coef=10'h3FF, data=10'h3FF → 10'h001.
- All four requesters held valid, out_ready=1 → grant order 0,1,2,3,0,… with one result per cycle, each out_id matching the coefficient applied.
- Backpressure: out_ready=0 for 5 cycles while requests are pending → exactly 2 requests accepted; out_data stable. On release, results arrive in order with no loss or duplication.
- Wrap case: data=10'h200, NEG → 10'h200 without TWNEG_SAT_EN, 10'h1FF with it.
- rst asserted for one cycle with both stages full → next cycle out_valid=0, busy=0. Requesters 2 and 3 valid afterwards → requester 2 is granted first, since ptr restarts at 0.

Source files
------------

// File: rtl/twiddle_negate_arbiter.sv
// twiddle_negate_arbiter: one shared, two-stage conditional-negate unit that
// applies the trivial twiddles 0, +1 and -1 to samples from NREQ round-robin
// requesters. Each result carries the id of the requester that produced it.
// Optional build macro TWNEG_SAT_EN: when defined, negating the most-negative
// sample saturates to the most-positive value. Otherwise the negation wraps.
module twiddle_negate_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 10,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_coef,
    input  logic [NREQ*W-1:0] req_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        OP_ZERO = 2'd0,
        OP_NEG  = 2'd1,
        OP_PASS = 2'd2
    } op_e;

    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

    // A zero coefficient selects ZERO, a negative one selects NEG, and any
    // other value selects PASS.
    function automatic op_e decode_coef(input logic [W-1:0] c);
        if (c == '0)
            return OP_ZERO;
        else if (c[W-1])
            return OP_NEG;
        else
            return OP_PASS;
    endfunction

    // Two's-complement negation. Only the most-negative input needs special
    // handling, because its negation does not fit in W bits.
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] d);
`ifdef TWNEG_SAT_EN
        if (d == MIN_V)
            return MAX_V;
`endif
        return -d;
    endfunction

    function automatic logic signed [W-1:0] apply_op(input op_e op,
                                                     input logic signed [W-1:0] d);
        case (op)
            OP_ZERO: return '0;
            OP_NEG:  return neg_sat(d);
            default: return d;
        endcase
    endfunction

    logic [IDW-1:0]        ptr_q, ptr_d;
    logic                  vld_p1_q, vld_p1_d;
    op_e                   op_p1_q, op_p1_d;
    logic signed [W-1:0]   data_p1_q, data_p1_d;
    logic [IDW-1:0]        id_p1_q, id_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic signed [W-1:0]   res_p2_q, res_p2_d;
    logic [IDW-1:0]        id_p2_q, id_p2_d;

    logic                  gnt_found;
    logic [IDW-1:0]        gnt_id;
    int                    scan_idx;
    logic                  s1_accept, s2_accept, req_hs;

    // Round-robin scan that starts at ptr and picks the first valid requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(scan_idx);
            end
        end
    end

    // Elastic handshake. req_ready is held at 0 during reset.
    always_comb begin
        s2_accept = !vld_p2_q || out_ready;
        s1_accept = !vld_p1_q || s2_accept;
        req_hs    = gnt_found && s1_accept && !rst;
        req_ready = '0;
        if (req_hs)
            req_ready[gnt_id] = 1'b1;
    end

    // Next-state logic for the pointer and both pipeline stages.
    always_comb begin
        ptr_d     = ptr_q;
        vld_p1_d  = vld_p1_q && !s2_accept;
        op_p1_d   = op_p1_q;
        data_p1_d = data_p1_q;
        id_p1_d   = id_p1_q;
        vld_p2_d  = vld_p2_q && !out_ready;
        res_p2_d  = res_p2_q;
        id_p2_d   = id_p2_q;
        if (req_hs) begin
            ptr_d     = IDW'((int'(gnt_id) + 1) % NREQ);
            vld_p1_d  = 1'b1;
            op_p1_d   = decode_coef(req_coef[int'(gnt_id)*W +: W]);
            data_p1_d = $signed(req_data[int'(gnt_id)*W +: W]);
            id_p1_d   = gnt_id;
        end
        if (vld_p1_q && s2_accept) begin
            vld_p2_d = 1'b1;
            res_p2_d = apply_op(op_p1_q, data_p1_q);
            id_p2_d  = id_p1_q;
        end
    end

    // Control state and the registered outputs, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
            id_p2_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
            id_p2_q  <= id_p2_d;
        end
    end

    // Stage-1 payload. Its contents only matter while vld_p1_q is set, so it has no reset.
    always_ff @(posedge clk) begin
        op_p1_q   <= op_p1_d;
        data_p1_q <= data_p1_d;
        id_p1_q   <= id_p1_d;
    end

    assign out_valid = vld_p2_q;
    assign out_data  = res_p2_q;
    assign out_id    = id_p2_q;
    assign busy      = vld_p1_q || vld_p2_q;

endmodule

// File: tb/tb_twiddle_negate_arbiter.sv
// Directed bench for twiddle_negate_arbiter with a result scoreboard.
module tb_twiddle_negate_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 10;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_coef;
    logic [NREQ*W-1:0] req_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              busy;

    logic [W-1:0] coef_a [NREQ];
    logic [W-1:0] data_a [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   d;
    } exp_t;

    exp_t sb[$];

    int nvec;
    int nfail;
    int tb_ptr;
    int last_hs;
    logic stalled;
    logic [W-1:0]   prev_data;
    logic [IDW-1:0] prev_id;

    twiddle_negate_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_coef  (req_coef),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_coef = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_coef[i*W +: W] = coef_a[i];
            req_data[i*W +: W] = data_a[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference behaviour of the unit, written from the twiddle definitions.
    function automatic logic [W-1:0] model(input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] r;
        if (c == '0) begin
            r = '0;
        end else if (c[W-1]) begin
            if (d == 10'h200) begin
`ifdef TWNEG_SAT_EN
                r = 10'h1FF;
`else
                r = 10'h200;
`endif
            end else begin
                r = (~d) + 10'd1;
            end
        end else begin
            r = d;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic cycle();
        int eg;
        exp_t e;
        @(negedge clk);
        last_hs = -1;
        if (rst) begin
            chk("ready_in_rst", 32'(req_ready), 32'd0);
            sb.delete();
            tb_ptr  = 0;
            stalled = 1'b0;
        end else begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (req_ready != '0) begin
                eg = -1;
                for (int k = 0; k < NREQ; k++)
                    if (eg < 0 && req_valid[(tb_ptr + k) % NREQ])
                        eg = (tb_ptr + k) % NREQ;
                chk("grant", 32'(req_ready), 32'(1 << eg));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = IDW'(i);
                    e.d  = model(coef_a[i], data_a[i]);
                    sb.push_back(e);
                    last_hs = i;
                    tb_ptr  = (i + 1) % NREQ;
                end
            end
            if (stalled) begin
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_id", 32'(out_id), 32'(prev_id));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_id", 32'(out_id), 32'(e.id));
                    chk("out_data", 32'(out_data), 32'(e.d));
                end
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_id   = out_id;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [W-1:0] c, input logic [W-1:0] d);
        logic got;
        got = 1'b0;
        coef_a[i] = c;
        data_a[i] = d;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            cycle();
            if (last_hs == i) got = 1'b1;
        end
        chk("send_accepted", 32'(got), 32'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && (busy || out_valid); n++)
            cycle();
        chk("drain_busy", 32'(busy), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int prev;
        int cnt;
        nvec = 0;
        nfail = 0;
        tb_ptr = 0;
        last_hs = -1;
        stalled = 1'b0;
        prev_data = '0;
        prev_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            coef_a[i] = '0;
            data_a[i] = '0;
        end
        rst = 1'b1;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;

        // Reset: req_ready must stay 0 even though a requester is valid.
        repeat (3) cycle();
        rst = 1'b0;
        req_valid = '0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single NEG request and its two-edge latency.
        send(0, 10'h200, 10'd37);
        chk("lat1_busy", 32'(busy), 32'd1);
        chk("lat1_out_valid", 32'(out_valid), 32'd0);
        cycle();
        chk("lat2_out_valid", 32'(out_valid), 32'd1);
        chk("lat2_busy", 32'(busy), 32'd1);
        chk("lat2_out_data", 32'(out_data), 32'h3DB);
        chk("lat2_out_id", 32'(out_id), 32'd0);
        cycle();
        chk("lat3_busy", 32'(busy), 32'd0);
        chk("lat3_out_valid", 32'(out_valid), 32'd0);

        // Decode cases and the wrap case.
        send(0, 10'h000, 10'd123);
        send(0, 10'h001, 10'd123);
        send(0, 10'h3FF, 10'h3FF);
        send(0, 10'h200, 10'h200);
        drain();

        // All requesters valid: one grant per cycle, in round-robin order.
        coef_a[0] = 10'h200; coef_a[1] = 10'h001;
        coef_a[2] = 10'h000; coef_a[3] = 10'h3FF;
        for (int i = 0; i < NREQ; i++) data_a[i] = W'($urandom);
        req_valid = 4'hF;
        out_ready = 1'b1;
        prev = -1;
        for (int n = 0; n < 12; n++) begin
            cycle();
            chk("hs_each_cycle", 32'(last_hs >= 0), 32'd1);
            if (prev >= 0)
                chk("rr_order", 32'(last_hs), 32'((prev + 1) % NREQ));
            prev = last_hs;
            if (last_hs >= 0) data_a[last_hs] = W'($urandom);
        end
        req_valid = '0;
        drain();

        // Backpressure: out_ready low for 5 cycles lets exactly 2 requests in.
        out_ready = 1'b0;
        req_valid = 4'hF;
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            if (last_hs >= 0) begin
                cnt++;
                data_a[last_hs] = W'($urandom);
            end
        end
        chk("bp_accepts", 32'(cnt), 32'd2);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        req_valid = '0;
        drain();

        // Reset with both stages full, then the first grant starts scanning at 0.
        out_ready = 1'b0;
        req_valid = 4'b0011;
        cycle();
        cycle();
        req_valid = '0;
        chk("full_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        coef_a[2] = 10'h001; data_a[2] = 10'd55;
        coef_a[3] = 10'h200; data_a[3] = 10'd66;
        req_valid = 4'b1100;
        out_ready = 1'b1;
        cycle();
        chk("post_rst_grant", 32'(last_hs), 32'd2);
        req_valid[2] = 1'b0;
        cycle();
        chk("post_rst_grant2", 32'(last_hs), 32'd3);
        req_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
